// File: rtl/sha3_byte_packer.sv
// rtl/sha3_byte_packer.sv - packs a byte stream into 64-bit words for the SHA-3 padder
module sha3_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [63:0] in,
  output logic        in_ready,
  output logic        is_last,
  output logic [2:0]  byte_num,
  input  logic        buffer_full,
  output logic        msg_done
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] FULL = 2'd1;
  localparam logic [1:0] LAST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] word_q, word_d;
  logic        last_pend_q, last_pend_d;

  logic        take_byte;
  logic        take_last;
  logic        word_xfer;

  // Handshake decode; byte_ready is held low while reset is asserted.
  always_comb begin
    byte_ready = 1'b0;
    if (reset) begin
      case (state_q)
        FILL:    byte_ready = 1'b1;
        FULL:    byte_ready = ~last_pend_q & ~buffer_full;
        default: byte_ready = 1'b0;
      endcase
    end
    in_ready  = ((state_q == FULL) || (state_q == LAST)) & ~buffer_full;
    is_last   = (state_q == LAST) & ~buffer_full;
    byte_num  = (state_q == LAST) ? cnt_q[2:0] : 3'd0;
    msg_done  = (state_q == DONE);
    in        = word_q;
    take_byte = byte_ready & byte_valid;
    take_last = byte_ready & byte_last;
    word_xfer = in_ready;
  end

  // Next-state logic; a FULL word that drains may accept the next byte in the same cycle.
  always_comb begin
    logic [3:0]  fill_cnt;
    logic [63:0] fill_word;
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    last_pend_d = last_pend_q;
    fill_cnt    = cnt_q;
    fill_word   = word_q;
    case (state_q)
      FILL, FULL: begin
        if (state_q == FULL) begin
          fill_cnt  = 4'd0;
          fill_word = 64'd0;
        end
        if (state_q == FULL && word_xfer && last_pend_q) begin
          word_d      = 64'd0;
          cnt_d       = 4'd0;
          last_pend_d = 1'b0;
          state_d     = LAST;
        end else if (state_q == FILL || word_xfer) begin
          word_d      = fill_word;
          cnt_d       = fill_cnt;
          last_pend_d = 1'b0;
          state_d     = FILL;
          if (take_byte) begin
            for (int k = 0; k < 8; k++) begin
              if (fill_cnt[2:0] == k[2:0]) word_d[63-8*k -: 8] = byte_in;
            end
            cnt_d = fill_cnt + 4'd1;
          end
          if (take_byte && fill_cnt == 4'd7) begin
            state_d     = FULL;
            last_pend_d = byte_last;
          end else if (take_last) begin
            state_d = LAST;
          end
        end
      end
      LAST: begin
        if (word_xfer) state_d = DONE;
      end
      default: state_d = DONE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      cnt_q       <= 4'd0;
      word_q      <= 64'd0;
      last_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      last_pend_q <= last_pend_d;
    end
  end

endmodule

// File: doc/sha3_byte_packer.md
# sha3_byte_packer

Upstream feeder for the 512-bit padder: packs a byte stream into 64-bit words and drives the padder's `in`/`in_ready`/`is_last`/`byte_num` interface. It honours the padder's `buffer_full` back-pressure and handles message-end alignment, including zero-length and 8-byte-aligned messages. One message is handled per reset, matching the padder's single-message behaviour.

## Interface
- No parameters. Word width is 64 and bytes per word is 8, both fixed.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-low reset.
- Clocking is fixed: one clock; reset is asynchronous and active-low.
- `byte_in` input 8: data byte.
- `byte_valid` input 1: `byte_in` carries a message byte.
- `byte_last` input 1: end-of-message strobe. It may be high with `byte_valid` low, meaning the message ends with no byte this cycle.
- `byte_ready` output 1: packer takes `byte_in`/`byte_last` this cycle.
- `in` output 64: word to padder. The first byte of a word is in `[63:56]`; unfilled bytes are 0.
- `in_ready` output 1: word valid to padder.
- `is_last` output 1: word is the final, partial word.
- `byte_num` output 3: valid byte count in the final word (0..7).
- `buffer_full` input 1: padder cannot accept.
- `msg_done` output 1: final word has been delivered.

## Operation
- **Handshake, byte side.** A byte is taken when `byte_ready & byte_valid`. The end strobe is taken when `byte_ready & byte_last`.
- **Handshake, word side.** A word transfers in any cycle with `in_ready` high. `in_ready` and `is_last` are combinationally gated by `~buffer_full`, so neither is ever high while `buffer_full` is high. This is mandatory: the padder latches end-of-message on `is_last` regardless of `buffer_full`.
- **Registers.**
  - `word[63:0]`: byte k of the word goes to bits `[63-8k:56-8k]`.
  - `cnt[3:0]`: 0..8.
  - `last_pend`: end seen while the word is full.
  - `state`: one of FILL, FULL, LAST, DONE.
- **FILL** (cnt 0..7). `byte_ready`=1.
  - Byte taken: write at `cnt`, then `cnt+1`.
  - `cnt+1==8`: go to FULL, with `last_pend` = `byte_last`.
  - Else, `byte_last` taken: go to LAST.
- **FULL** (cnt==8, non-final word held). `in_ready`=`~buffer_full`, `is_last`=0. On transfer:
  - If `last_pend`: clear `word`, set `cnt`=0, go to LAST.
  - Else: clear `word`, set `cnt`=0, go to FILL, and handle any simultaneously accepted byte/strobe as in FILL. The byte lands in `[63:56]` with `cnt`=1; a strobe leads to LAST.
  - `byte_ready` = `~last_pend & ~buffer_full`.
- **LAST.** `byte_ready`=0, `in_ready`=`is_last`=`~buffer_full`, `byte_num`=`cnt[2:0]`. On transfer, go to DONE.
- **DONE.** `byte_ready`=0, `in_ready`=`is_last`=0, `msg_done`=1. Stays there until reset; inputs are ignored.
- `byte_num` is 0 outside LAST. `in` always equals `word`.
- **Alignment.**
  - An 8-byte-aligned message yields a full word with `is_last`=0, then `in`=0 with `is_last`=1 and `byte_num`=0.
  - An end strobe alone at `cnt`=0 yields a single word `in`=0 with `is_last`=1 and `byte_num`=0.

## Timing
- **Reset.** While `reset` is low, all registers clear asynchronously: state FILL, `cnt`=0, `word`=0, `last_pend`=0. Outputs during reset: `in`=0, `in_ready`=0, `is_last`=0, `byte_num`=0, `msg_done`=0, and `byte_ready` is forced 0. `byte_ready`=1 from the first cycle after release.
- **Latency.** The byte completing a word (or the end strobe) is taken in cycle N. `in_ready` can assert in cycle N+1.
- **Throughput.** Continuous streaming sustains 1 byte/cycle with no bubble at word boundaries while `buffer_full` stays low.
- **Back-pressure.** While `buffer_full` is high, the held word and `cnt` are stable. FULL/LAST outputs are 0, and FULL `byte_ready` is 0.
- **Reset mid-operation.** A partial word is discarded. No transfer occurs in the release cycle.

## Test plan
1. Bytes AA, BB, CC with `byte_last` on CC, `buffer_full`=0 → one transfer: `in`=0xAABBCC0000000000, `is_last`=1, `byte_num`=3. Then `msg_done`=1 and `byte_ready`=0.
2. Bytes 01..08 with `byte_last` on 08 → transfer `in`=0x0102030405060708, `is_last`=0. Next cycle: `in`=0, `is_last`=1, `byte_num`=0.
3. `byte_last` alone with `byte_valid`=0 immediately after reset → single transfer `in`=0, `is_last`=1, `byte_num`=0, then DONE.
4. Hold `buffer_full`=1 for 20 cycles while FULL, with bytes offered → `in_ready`=0 and `byte_ready`=0 throughout, `in` stable. Drop it → exactly one transfer, and the offered byte is taken in that same cycle into `[63:56]`.
5. 16 back-to-back bytes 00..0F, then `byte_last` alone, `buffer_full`=0 → `byte_ready` never drops. Transfers, in order: 0x0001020304050607, 0x08090A0B0C0D0E0F, then `in`=0 with `is_last`=1, `byte_num`=0.
6. Assert `reset` low mid-word with `cnt`=5 → outputs go to 0 before the next edge. After release, 2 bytes plus `byte_last` yield `byte_num`=2 with only those bytes present.
